// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one memory port between fetch and LSU.
// LSU has priority; a starvation counter forces a fetch grant when saturated.
module mem_port_arbiter #(
  parameter int Width      = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             if_req_i,
  input  logic [Width-1:0] if_addr_i,
  input  logic             if_flush_i,
  output logic             if_gnt_o,
  output logic             if_rvalid_o,
  output logic [Width-1:0] if_rdata_o,
  output logic             if_stall_o,
  input  logic             ls_req_i,
  input  logic             ls_we_i,
  input  logic [Width-1:0] ls_addr_i,
  input  logic [Width-1:0] ls_wdata_i,
  input  logic [3:0]       ls_be_i,
  output logic             ls_gnt_o,
  output logic             ls_rvalid_o,
  output logic [Width-1:0] ls_rdata_o,
  output logic             ls_stall_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [Width-1:0] mem_addr_o,
  output logic [Width-1:0] mem_wdata_o,
  output logic [3:0]       mem_be_o,
  input  logic             mem_ready_i,
  input  logic [Width-1:0] mem_rdata_i
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;
  typedef enum logic {OWN_IF, OWN_LS} own_t;

  state_t           r_state;
  state_t           w_next;
  own_t             r_own;
  logic             r_we;
  logic [Width-1:0] r_addr;
  logic [Width-1:0] r_wdata;
  logic [3:0]       r_be;
  logic             r_discard;
  logic [CW-1:0]    r_starve;
  logic             r_if_rvalid;
  logic             r_ls_rvalid;
  logic [Width-1:0] r_if_rdata;
  logic [Width-1:0] r_ls_rdata;

  logic w_free;
  logic w_done;
  logic w_starved;
  logic w_if_gnt;
  logic w_ls_gnt;
  logic w_if_drop;

  // Grant decision and next state; free when idle or the access completes
  always_comb begin
    w_if_gnt  = 1'b0;
    w_ls_gnt  = 1'b0;
    w_next    = r_state;
    w_done    = (r_state == S_BUSY) && mem_ready_i;
    w_free    = (r_state == S_IDLE) || w_done;
    w_starved = (r_starve == CW'(STARVE_MAX));
    if (w_free) begin
      if (ls_req_i && !(if_req_i && w_starved)) begin
        w_ls_gnt = 1'b1;
      end else if (if_req_i) begin
        w_if_gnt = 1'b1;
      end
      w_next = (w_ls_gnt || w_if_gnt) ? S_BUSY : S_IDLE;
    end
  end

  assign w_if_drop   = r_discard || if_flush_i;
  assign if_gnt_o    = w_if_gnt;
  assign ls_gnt_o    = w_ls_gnt;
  assign if_stall_o  = if_req_i && !w_if_gnt;
  assign ls_stall_o  = ls_req_i && !w_ls_gnt;
  assign mem_req_o   = (r_state == S_BUSY);
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mem_be_o    = r_be;
  assign if_rvalid_o = r_if_rvalid;
  assign ls_rvalid_o = r_ls_rvalid;
  assign if_rdata_o  = r_if_rdata;
  assign ls_rdata_o  = r_ls_rdata;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Capture the granted request; fields stay stable until the next grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_own   <= OWN_IF;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= 4'h0;
    end else if (w_ls_gnt) begin
      r_own   <= OWN_LS;
      r_we    <= ls_we_i;
      r_addr  <= ls_addr_i;
      r_wdata <= ls_wdata_i;
      r_be    <= ls_be_i;
    end else if (w_if_gnt) begin
      r_own   <= OWN_IF;
      r_we    <= 1'b0;
      r_addr  <= if_addr_i;
      r_wdata <= '0;
      r_be    <= 4'hF;
    end
  end

  // Register the completion as a one-cycle response to the owner
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rdata  <= '0;
    end else begin
      r_if_rvalid <= w_done && (r_own == OWN_IF) && !w_if_drop;
      r_ls_rvalid <= w_done && (r_own == OWN_LS);
      if (w_done && (r_own == OWN_IF) && !w_if_drop)
        r_if_rdata <= mem_rdata_i;
      if (w_done && (r_own == OWN_LS))
        r_ls_rdata <= r_we ? '0 : mem_rdata_i;
    end
  end

  // Discard flag: a flushed fetch still completes on the bus but is dropped
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_discard <= 1'b0;
    end else if (w_if_gnt) begin
      r_discard <= if_flush_i;
    end else if (w_done) begin
      r_discard <= 1'b0;
    end else if ((r_state == S_BUSY) && (r_own == OWN_IF) && if_flush_i) begin
      r_discard <= 1'b1;
    end
  end

  // Starvation counter for denied fetch cycles, saturating
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_starve <= '0;
    end else if (w_if_gnt || !if_req_i) begin
      r_starve <= '0;
    end else if (if_stall_o && !w_starved) begin
      r_starve <= r_starve + CW'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Stimulus pushes expected responses; a monitor pops them on rvalid.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush, ls_req, ls_we, mem_ready;
  logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic [3:0]  ls_be;
  logic        if_gnt, if_rvalid, if_stall;
  logic        ls_gnt, ls_rvalid, ls_stall;
  logic [31:0] if_rdata, ls_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  typedef struct {
    bit          ls;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.Width(32), .STARVE_MAX(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid),
    .if_rdata_o(if_rdata), .if_stall_o(if_stall),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr),
    .ls_wdata_i(ls_wdata), .ls_be_i(ls_be),
    .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid),
    .ls_rdata_o(ls_rdata), .ls_stall_o(ls_stall),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
    .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic push(input bit ls, input logic [31:0] d);
    exp_t e;
    e.ls   = ls;
    e.data = d;
    q.push_back(e);
  endtask

  task automatic clr();
    if_req    = 1'b0;
    if_addr   = '0;
    if_flush  = 1'b0;
    ls_req    = 1'b0;
    ls_we     = 1'b0;
    ls_addr   = '0;
    ls_wdata  = '0;
    ls_be     = 4'h0;
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    clr();
  endtask

  // Monitor: every rvalid must match the oldest expected response
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_rvalid || ls_rvalid) begin
        checks++;
        if (if_rvalid && ls_rvalid) begin
          failures++;
          $display("FAIL both_rvalid actual=11 required=one");
        end else if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_rvalid if=%b ls=%b required=none",
                   if_rvalid, ls_rvalid);
        end else begin
          e = q.pop_front();
          if (e.ls != ls_rvalid) begin
            failures++;
            $display("FAIL rvalid_port actual_ls=%b required_ls=%b",
                     ls_rvalid, e.ls);
          end else if ((ls_rvalid ? ls_rdata : if_rdata) !== e.data) begin
            failures++;
            $display("FAIL rdata actual=%h required=%h",
                     ls_rvalid ? ls_rdata : if_rdata, e.data);
          end
        end
      end
    end
  end

  initial begin
    clr();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", 32'(mem_be), 0);
    chk("rst_rvalid", {30'd0, if_rvalid, ls_rvalid}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();

    // Single fetch read
    cyc(); if_req = 1; if_addr = 32'h100; mem_ready = 1;
    #1;
    chk("t1_if_gnt", 32'(if_gnt), 1);
    chk("t1_ls_gnt", 32'(ls_gnt), 0);
    chk("t1_mem_req_n", 32'(mem_req), 0);
    push(0, 32'hDEADBEEF);
    cyc(); mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("t1_mem_req", 32'(mem_req), 1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_mem_we", 32'(mem_we), 0);
    chk("t1_mem_be", 32'(mem_be), 32'hF);
    cyc();
    #1 chk("t1_idle", 32'(mem_req), 0);

    // Simultaneous requests: store wins, fetch follows
    cyc(); if_req = 1; if_addr = 32'h200;
    ls_req = 1; ls_we = 1; ls_addr = 32'h7F0;
    ls_wdata = 32'h55; ls_be = 4'h1; mem_ready = 1;
    #1;
    chk("t2_ls_gnt", 32'(ls_gnt), 1);
    chk("t2_if_gnt", 32'(if_gnt), 0);
    chk("t2_if_stall", 32'(if_stall), 1);
    push(1, 32'h0);
    cyc(); if_req = 1; if_addr = 32'h200;
    mem_ready = 1; mem_rdata = 32'h12345678;
    #1;
    chk("t2_if_gnt2", 32'(if_gnt), 1);
    chk("t2_mem_we", 32'(mem_we), 1);
    chk("t2_mem_addr", mem_addr, 32'h7F0);
    chk("t2_mem_wdata", mem_wdata, 32'h55);
    chk("t2_mem_be", 32'(mem_be), 32'h1);
    push(0, 32'hCAFEF00D);
    cyc(); mem_ready = 1; mem_rdata = 32'hCAFEF00D;
    #1;
    chk("t2_if_addr", mem_addr, 32'h200);
    chk("t2_if_we", 32'(mem_we), 0);
    chk("t2_if_wdata", mem_wdata, 0);
    chk("t2_if_be", 32'(mem_be), 32'hF);
    cyc();

    // Starvation: four loads then forced fetch grant
    for (int c = 1; c <= 5; c++) begin
      cyc(); if_req = 1; if_addr = 32'h300;
      ls_req = 1; ls_addr = 32'h400 + 32'(4 * c);
      mem_ready = 1; mem_rdata = 32'hA0000000 + 32'(c);
      #1;
      if (c > 1)
        chk("t3_mem_addr", mem_addr, 32'h400 + 32'(4 * (c - 1)));
      if (c < 5) begin
        chk("t3_ls_gnt", 32'(ls_gnt), 1);
        chk("t3_if_gnt", 32'(if_gnt), 0);
        push(1, 32'hA0000000 + 32'(c + 1));
      end else begin
        chk("t3_if_forced", 32'(if_gnt), 1);
        chk("t3_ls_stall", 32'(ls_stall), 1);
        push(0, 32'hA0000006);
      end
    end
    cyc(); if_req = 1; if_addr = 32'h300;
    ls_req = 1; ls_addr = 32'h480;
    mem_ready = 1; mem_rdata = 32'hA0000006;
    #1;
    chk("t3_cnt_cleared", 32'(ls_gnt), 1);
    chk("t3_if_addr", mem_addr, 32'h300);
    push(1, 32'hA0000007);
    cyc(); mem_ready = 1; mem_rdata = 32'hA0000007;
    #1 chk("t3_ls_addr", mem_addr, 32'h480);
    cyc();

    // Fetch flushed during a 3-cycle wait
    cyc(); if_req = 1; if_addr = 32'h500;
    #1 chk("t4_if_gnt", 32'(if_gnt), 1);
    for (int w = 0; w < 4; w++) begin
      cyc();
      if (w == 1) if_flush = 1;
      if (w == 3) begin
        mem_ready = 1;
        mem_rdata = 32'hBAD0BAD0;
      end
      #1;
      chk("t4_hold_req", 32'(mem_req), 1);
      chk("t4_hold_addr", mem_addr, 32'h500);
      chk("t4_hold_be", 32'(mem_be), 32'hF);
    end
    cyc(); if_req = 1; if_addr = 32'h600; mem_ready = 1;
    #1;
    chk("t4_no_rvalid", 32'(if_rvalid), 0);
    chk("t4_req_drop", 32'(mem_req), 0);
    chk("t4_if_gnt2", 32'(if_gnt), 1);
    push(0, 32'h0600600D);
    cyc(); mem_ready = 1; mem_rdata = 32'h0600600D;
    #1 chk("t4_addr2", mem_addr, 32'h600);
    cyc();

    // Reset in the middle of an outstanding access
    cyc(); ls_req = 1; ls_addr = 32'h700;
    #1 chk("t5_ls_gnt", 32'(ls_gnt), 1);
    cyc();
    #1 chk("t5_busy", 32'(mem_req), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_req", 32'(mem_req), 0);
    chk("t5_rst_addr", mem_addr, 0);
    cyc(); mem_ready = 1; mem_rdata = 32'hDEAD0000;
    #1 rst_n = 1'b1;
    cyc(); mem_ready = 1; mem_rdata = 32'hDEAD0001;
    #1 chk("t5_no_rvalid", {30'd0, if_rvalid, ls_rvalid}, 0);
    cyc(); if_req = 1; if_addr = 32'h800; mem_ready = 1;
    #1;
    chk("t5_idle", 32'(mem_req), 0);
    chk("t5_if_gnt", 32'(if_gnt), 1);
    push(0, 32'h08000800);
    cyc(); mem_ready = 1; mem_rdata = 32'h08000800;
    #1 chk("t5_addr", mem_addr, 32'h800);
    repeat (3) cyc();

    chk("queue_empty", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter Width, default 32, the data/address width.
REQ-002 SHALL have parameter STARVE_MAX, default 4, the consecutive denied IF-request cycles before IF gets priority.
REQ-003 SHALL have clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_ni, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have if_req_i input 1, if_addr_i input Width, if_flush_i input 1 (discard pending fetch): the fetch requester.
REQ-006 SHALL have if_gnt_o output 1, if_rvalid_o output 1, if_rdata_o output Width, if_stall_o output 1: the fetch responses.
REQ-007 SHALL have ls_req_i input 1, ls_we_i input 1, ls_addr_i input Width, ls_wdata_i input Width, ls_be_i input 4: the LSU requester.
REQ-008 SHALL have ls_gnt_o output 1, ls_rvalid_o output 1, ls_rdata_o output Width, ls_stall_o output 1: the LSU responses.
REQ-009 SHALL have mem_req_o output 1, mem_we_o output 1, mem_addr_o output Width, mem_wdata_o output Width, mem_be_o output 4: the shared memory port.
REQ-010 SHALL have mem_ready_i input 1 (access completes this cycle) and mem_rdata_i input Width (read data, valid when mem_ready_i=1).

Function
REQ-011 SHALL implement FSM states IDLE (no access outstanding) and BUSY (one access outstanding); owner register OWN in {IF, LS}.
REQ-012 SHALL consider the arbiter free in IDLE, or in BUSY in a cycle with mem_ready_i=1.
REQ-013 SHALL, when free and at least one req_i is high, assert exactly one gnt_o combinationally in that cycle (N).
REQ-014 SHALL grant LS over IF when both request, unless starve_cnt equals STARVE_MAX, then grant IF.
REQ-015 SHALL, on grant, capture addr/we/wdata/be (IF: we=0, be=4'hF, wdata=0) and OWN, and enter BUSY; requester may drop req_i from N+1.
REQ-016 SHALL drive mem_req_o=1 with captured fields from N+1 until the cycle mem_ready_i=1, fields held stable throughout.
REQ-017 SHALL, when free with no request, return to IDLE with mem_req_o=0 next cycle.
REQ-018 SHALL, in the cycle after mem_ready_i=1, pulse OWN's rvalid_o for one cycle with rdata_o = registered mem_rdata_i; writes also pulse rvalid_o with rdata_o=0.
REQ-019 SHALL, with mem_ready_i=1 every cycle, sustain one access per cycle with no bubble; latency gnt->rvalid = 2 cycles.
REQ-020 SHALL drive x_stall_o = x_req_i AND NOT x_gnt_o, combinationally.
REQ-021 SHALL keep starve_cnt (saturating at STARVE_MAX): increment each cycle if_stall_o=1, clear on if_gnt_o=1 or if_req_i=0.
REQ-022 SHALL, when if_flush_i=1 while OWN=IF and BUSY, or in the cycle of the IF grant, set a discard flag; the memory access still completes but if_rvalid_o stays 0 for it; flag clears at completion.
REQ-023 SHALL ignore if_flush_i when no IF access is outstanding; if_flush_i SHALL NOT block a new IF grant in the same cycle unless it is the granted one (REQ-022).
REQ-024 SHALL never assert if_gnt_o and ls_gnt_o in the same cycle, nor both rvalid_o in the same cycle.

Reset
REQ-025 SHALL, on rst_ni=0, immediately force IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o/wdata_o=0, mem_be_o=0, all rvalid_o=0, rdata_o=0, starve_cnt=0, discard=0.
REQ-026 SHALL drop any outstanding access on reset with no rvalid_o after rst_ni rises; gnt_o/stall_o remain combinational and follow req_i.

Verification
REQ-027 SHALL cover: IF read 0x100, mem_ready_i=1, mem_rdata_i=0xDEADBEEF -> if_gnt_o N, mem_req_o N+1 addr 0x100, if_rvalid_o N+2 rdata 0xDEADBEEF.
REQ-028 SHALL cover: IF and LS request together, LS store addr 0x7F0 wdata 0x55 be 4'h1 -> ls_gnt_o first, if_stall_o=1, IF granted next cycle, ls_rvalid_o rdata 0.
REQ-029 SHALL cover: LS requests 5 consecutive cycles with IF held high, STARVE_MAX=4 -> IF granted on 5th opportunity, starve_cnt returns 0.
REQ-030 SHALL cover: IF read, mem_ready_i low 3 cycles, if_flush_i pulsed in wait -> mem_req_o held 4 cycles stable, no if_rvalid_o; subsequent IF read returns normally.
REQ-031 SHALL cover: rst_ni dropped mid-BUSY -> mem_req_o=0 same cycle, no rvalid_o after rst_ni rises, first post-reset request granted in IDLE.
